// File: rtl/ebu_nway_arb_if.sv
// ebu_nway_arb_if: request/grant bundle between the bus requesters and the AHB manager arbiter
interface ebu_nway_arb_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0] req;
  logic [2:0] hburst;
  logic hready;
  logic [NREQ-1:0] grant;
  logic [$clog2(NREQ)-1:0] owner;
  logic [NREQ-1:0] save;
  logic [NREQ-1:0] restore;
  logic [NREQ-1:0] dis;
  modport master (output req, hburst, hready, input grant, owner, save, restore, dis);
  modport slave (input req, hburst, hready, output grant, owner, save, restore, dis);
endinterface

// File: rtl/ebu_nway_arb.sv
// ebu_nway_arb: N-requester AHB manager arbiter with burst locking and save/restore strobes
module ebu_nway_arb #(
  parameter int NREQ = 3,
  parameter bit RR = 1'b1
) (
  input logic hclk,
  input logic hreset,
  ebu_nway_arb_if.slave bus
);
  localparam int W = $clog2(NREQ);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  logic [0:0] state;
  logic [W-1:0] owner, last, w;
  logic [NREQ-1:0] served, saved, elig, own_oh, others, win_oh, lost;
  logic [3:0] thr, thr_eff, cnt;
  logic fbd, fresh, multi, contend, done, sel, nxt_locked, fb;
  // Round-robin scans the doubled vector for the first set bit above last.
  function automatic logic [W-1:0] pick(input logic [NREQ-1:0] e, input logic [W-1:0] l);
    logic [2*NREQ-1:0] d;
    int p;
    d = {e, e};
    p = 0;
    for (int i = 2 * NREQ - 1; i >= 0; i--)
      if (d[i] && (RR ? i > int'(l) : i < NREQ)) p = i;
    return W'(p >= NREQ ? p - NREQ : p);
  endfunction
  always_comb begin
    elig = bus.req & ~served;
    own_oh = NREQ'(1) << owner;
    multi = |(elig & (elig - NREQ'(1)));
    contend = state == IDLE && multi;
    done = state == LOCKED && bus.hready && fbd;
    others = elig & ~own_oh;
    sel = contend || (done && (|others));
    w = pick(contend ? elig : others, last);
    win_oh = NREQ'(1) << w;
    nxt_locked = state == IDLE ? multi : !done || (|others);
    thr_eff = contend || fresh ? {&bus.hburst[2:1], bus.hburst[2], |bus.hburst[2:1], |bus.hburst[2:1]} : thr;
    fb = cnt == thr_eff;
    lost = contend && !hreset ? elig & ~win_oh : '0;
    bus.grant = hreset || (state == IDLE && !multi) ? elig : state == LOCKED ? own_oh : win_oh;
    bus.save = lost;
    bus.restore = state == LOCKED && !hreset ? own_oh & saved : '0;
    bus.dis = hreset ? '0 : (bus.req & served) | (state == LOCKED ? bus.req & ~own_oh : '0);
    bus.owner = owner;
  end
  // A new owner's beat count starts in its first granted cycle (fresh).
  always_ff @(posedge hclk or posedge hreset)
    if (hreset) begin
      state <= IDLE;
      owner <= '0;
      last <= W'(NREQ - 1);
      served <= '0;
      saved <= '0;
      thr <= '0;
      cnt <= '0;
      fbd <= 1'b0;
      fresh <= 1'b0;
    end else begin
      state <= nxt_locked ? LOCKED : IDLE;
      served <= (served | (done ? own_oh : '0)) & bus.req;
      saved <= nxt_locked ? saved | lost : '0;
      thr <= thr_eff;
      fresh <= done && (|others);
      owner <= !nxt_locked ? '0 : sel ? w : owner;
      last <= sel ? w : last;
      cnt <= !nxt_locked || done ? '0 : bus.hready ? (fb ? '0 : cnt + 4'd1) : cnt;
      fbd <= !nxt_locked || done ? 1'b0 : bus.hready ? fb : fbd;
    end
endmodule

// File: tb/tb_ebu_nway_arb.sv
// tb_ebu_nway_arb: directed vectors and multi-cycle sequences for fixed and round-robin arbiters
module tb_ebu_nway_arb;
  localparam int N = 3;
  typedef struct packed {
    logic rst;
    logic [2:0] req;
    logic [2:0] hb;
    logic hr;
    logic [2:0] grant;
    logic [2:0] save;
    logic [2:0] restore;
    logic [2:0] dis;
    logic [1:0] owner;
  } vec_t;
  logic hclk = 1'b0;
  logic hreset = 1'b0;
  logic [N-1:0] req = '0;
  logic [2:0] hburst = '0;
  logic hready = 1'b1;
  int checks = 0;
  int passed = 0;
  vec_t tbl [17];
  logic [2:0] rot_g [7] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b000};
  logic [1:0] rot_o [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
  logic hr_pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  ebu_nway_arb_if #(.NREQ(N)) bf ();
  ebu_nway_arb_if #(.NREQ(N)) br ();
  assign bf.req = req;
  assign bf.hburst = hburst;
  assign bf.hready = hready;
  assign br.req = req;
  assign br.hburst = hburst;
  assign br.hready = hready;
  ebu_nway_arb #(.NREQ(N), .RR(1'b0)) u_fix (.hclk(hclk), .hreset(hreset), .bus(bf));
  ebu_nway_arb #(.NREQ(N), .RR(1'b1)) u_rr (.hclk(hclk), .hreset(hreset), .bus(br));
  always #5 hclk = ~hclk;
  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b", nm, act, exp);
  endtask
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask
  task automatic drive(input logic [N-1:0] r, input logic [2:0] hb, input logic hr);
    req = r;
    hburst = hb;
    hready = hr;
    #2;
  endtask
  task automatic do_reset();
    hreset = 1'b1;
    req = '0;
    #2;
    tick();
    hreset = 1'b0;
  endtask
  initial begin
    //            rst   req     hb      hr    grant   save    restore dis     owner
    tbl[0]  = '{1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 2'd0};
    tbl[1]  = '{1'b0, 3'b011, 3'b000, 1'b1, 3'b001, 3'b010, 3'b000, 3'b000, 2'd0};
    tbl[2]  = '{1'b0, 3'b011, 3'b000, 1'b1, 3'b001, 3'b000, 3'b000, 3'b010, 2'd0};
    tbl[3]  = '{1'b0, 3'b011, 3'b000, 1'b1, 3'b010, 3'b000, 3'b010, 3'b001, 2'd1};
    tbl[4]  = '{1'b0, 3'b011, 3'b000, 1'b1, 3'b010, 3'b000, 3'b010, 3'b001, 2'd1};
    tbl[5]  = '{1'b0, 3'b011, 3'b000, 1'b1, 3'b000, 3'b000, 3'b000, 3'b011, 2'd0};
    tbl[6]  = '{1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 2'd0};
    tbl[7]  = '{1'b0, 3'b001, 3'b000, 1'b1, 3'b001, 3'b000, 3'b000, 3'b000, 2'd0};
    tbl[8]  = '{1'b0, 3'b100, 3'b011, 1'b1, 3'b100, 3'b000, 3'b000, 3'b000, 2'd0};
    tbl[9]  = '{1'b0, 3'b100, 3'b111, 1'b1, 3'b100, 3'b000, 3'b000, 3'b000, 2'd0};
    tbl[10] = '{1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 2'd0};
    tbl[11] = '{1'b0, 3'b101, 3'b101, 1'b1, 3'b001, 3'b100, 3'b000, 3'b000, 2'd0};
    tbl[12] = '{1'b0, 3'b101, 3'b101, 1'b1, 3'b001, 3'b000, 3'b000, 3'b100, 2'd0};
    tbl[13] = '{1'b1, 3'b101, 3'b101, 1'b1, 3'b101, 3'b000, 3'b000, 3'b000, 2'd0};
    tbl[14] = '{1'b0, 3'b101, 3'b101, 1'b1, 3'b001, 3'b100, 3'b000, 3'b000, 2'd0};
    tbl[15] = '{1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 2'd0};
    tbl[16] = '{1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 2'd0};
    #1 hreset = 1'b1;
    for (int i = 0; i < 17; i++) begin
      hreset = tbl[i].rst;
      drive(tbl[i].req, tbl[i].hb, tbl[i].hr);
      chk($sformatf("v%0d grant", i), bf.grant, tbl[i].grant);
      chk($sformatf("v%0d save", i), bf.save, tbl[i].save);
      chk($sformatf("v%0d restore", i), bf.restore, tbl[i].restore);
      chk($sformatf("v%0d disable", i), bf.dis, tbl[i].dis);
      chk($sformatf("v%0d owner", i), {1'b0, bf.owner}, {1'b0, tbl[i].owner});
      tick();
    end
    // round-robin rotation 0,1,2 then a fresh contest restarts at index 0
    for (int c = 0; c < 7; c++) begin
      drive(3'b111, 3'b000, 1'b1);
      chk($sformatf("rot%0d grant", c), br.grant, rot_g[c]);
      chk($sformatf("rot%0d owner", c), {1'b0, br.owner}, {1'b0, rot_o[c]});
      tick();
    end
    drive(3'b000, 3'b000, 1'b1);
    tick();
    drive(3'b111, 3'b000, 1'b1);
    chk("rot_again grant", br.grant, 3'b001);
    chk("rot_again save", br.save, 3'b110);
    do_reset();
    // after 0 then 1 win, round-robin favours 2 where fixed favours 0
    for (int c = 0; c < 5; c++) begin
      drive(3'b011, 3'b000, 1'b1);
      tick();
    end
    drive(3'b000, 3'b000, 1'b1);
    tick();
    drive(3'b101, 3'b000, 1'b1);
    chk("policy rr grant", br.grant, 3'b100);
    chk("policy rr save", br.save, 3'b001);
    chk("policy fix grant", bf.grant, 3'b001);
    chk("policy fix save", bf.save, 3'b100);
    do_reset();
    // INCR4 with wait states releases after the fifth ready beat
    for (int c = 0; c < 8; c++) begin
      drive(3'b011, 3'b011, hr_pat[c]);
      if (c == 0) chk("incr4 c0 save", br.save, 3'b010);
      chk($sformatf("incr4 c%0d grant", c), br.grant, c < 7 ? 3'b001 : 3'b010);
      if (c > 0 && c < 7) chk($sformatf("incr4 c%0d disable", c), br.dis, 3'b010);
      tick();
    end
    do_reset();
    // INCR16 back to back: each owner holds exactly 17 cycles, no early release
    for (int c = 0; c < 35; c++) begin
      drive(3'b011, 3'b111, 1'b1);
      chk($sformatf("incr16 c%0d grant", c), br.grant, c < 17 ? 3'b001 : c < 34 ? 3'b010 : 3'b000);
      tick();
    end
    do_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
